// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
// Arbitrates two requesters onto one shared external 4-bit combinational ALU.
// Each operation takes IDLE (grant) -> EXEC (ALU evaluates) -> RESP (pulse).
//
// Parameters
//   RR_EN        1 = round-robin on contention, 0 = requester 0 always wins
// Ports
//   clk, rst                       clock, async active-high reset
//   reqN_valid/a/b/sel             requester N operation (N = 0, 1)
//   reqN_ready                     requester N accepted this cycle (comb.)
//   rsp0_valid, rsp1_valid         one-cycle response pulse per requester
//   rsp_y, rsp_err                 shared result / illegal-opcode flag
//   alu_a, alu_b, alu_sel, alu_y   external ALU operands and result
//   busy                           state is not IDLE
//   op_count                       completed responses, wraps at 256
// ---------------------------------------------------------------------------
module alu_arbiter #(
  parameter bit RR_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [3:0] req0_a,
  input  logic [3:0] req0_b,
  input  logic [2:0] req0_sel,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [3:0] req1_a,
  input  logic [3:0] req1_b,
  input  logic [2:0] req1_sel,
  output logic       req1_ready,
  output logic       rsp0_valid,
  output logic       rsp1_valid,
  output logic [3:0] rsp_y,
  output logic       rsp_err,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [2:0] alu_sel,
  input  logic [3:0] alu_y,
  output logic       busy,
  output logic [7:0] op_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_next_state;
  logic       w_grant;
  logic       w_gnt_id;
  logic       w_illegal;
  logic       r_last_grant;
  logic       r_gnt_id;
  logic [3:0] r_alu_a;
  logic [3:0] r_alu_b;
  logic [2:0] r_alu_sel;
  logic [3:0] r_y;
  logic       r_err;
  logic       r_rsp0;
  logic       r_rsp1;
  logic [7:0] r_count;

  // Opcodes 101..111 are illegal.
  assign w_illegal = (r_alu_sel > 3'd4);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Arbitration, next-state decode and combinational ready outputs.
  always_comb begin
    w_next_state = r_state;
    w_grant      = 1'b0;
    w_gnt_id     = 1'b0;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    // Contention under round-robin goes to whoever did not win last time;
    // otherwise requester 0 wins if valid, else requester 1.
    if (RR_EN && req0_valid && req1_valid) begin
      w_gnt_id = ~r_last_grant;
    end else begin
      w_gnt_id = ~req0_valid;
    end
    case (r_state)
      ST_IDLE: begin
        if (req0_valid || req1_valid) begin
          w_grant      = 1'b1;
          req0_ready   = ~w_gnt_id;
          req1_ready   = w_gnt_id;
          w_next_state = ST_EXEC;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_EXEC: w_next_state = ST_RESP;
      ST_RESP: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Operand capture on grant, result capture in EXEC, response and counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_grant <= 1'b1;
      r_gnt_id     <= 1'b0;
      r_alu_a      <= 4'd0;
      r_alu_b      <= 4'd0;
      r_alu_sel    <= 3'd0;
      r_y          <= 4'd0;
      r_err        <= 1'b0;
      r_rsp0       <= 1'b0;
      r_rsp1       <= 1'b0;
      r_count      <= 8'd0;
    end else begin
      if (w_grant) begin
        r_gnt_id     <= w_gnt_id;
        r_last_grant <= w_gnt_id;
        r_alu_a      <= w_gnt_id ? req1_a   : req0_a;
        r_alu_b      <= w_gnt_id ? req1_b   : req0_b;
        r_alu_sel    <= w_gnt_id ? req1_sel : req0_sel;
      end
      // Result and flag change only when a response is about to be issued,
      // so they hold their last value between pulses.
      if (r_state == ST_EXEC) begin
        r_y   <= w_illegal ? 4'd0 : alu_y;
        r_err <= w_illegal;
      end
      r_rsp0 <= (r_state == ST_EXEC) && !r_gnt_id;
      r_rsp1 <= (r_state == ST_EXEC) &&  r_gnt_id;
      if (r_state == ST_RESP) begin
        r_count <= r_count + 8'd1;
      end
    end
  end

  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_sel    = r_alu_sel;
  assign rsp_y      = r_y;
  assign rsp_err    = r_err;
  assign rsp0_valid = r_rsp0;
  assign rsp1_valid = r_rsp1;
  assign op_count   = r_count;
  assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
// Directed bench: one round-robin instance (rr_*) and one fixed-priority
// instance (fp_*), each with its own behavioural ALU model on alu_y.
// ---------------------------------------------------------------------------
module tb_alu_arbiter;

  logic clk;
  logic rst;

  logic       rr_req0_valid, rr_req1_valid, rr_req0_ready, rr_req1_ready;
  logic [3:0] rr_req0_a, rr_req0_b, rr_req1_a, rr_req1_b;
  logic [2:0] rr_req0_sel, rr_req1_sel;
  logic       rr_rsp0_valid, rr_rsp1_valid, rr_rsp_err, rr_busy;
  logic [3:0] rr_rsp_y, rr_alu_a, rr_alu_b, rr_alu_y;
  logic [2:0] rr_alu_sel;
  logic [7:0] rr_op_count;

  logic       fp_req0_valid, fp_req1_valid, fp_req0_ready, fp_req1_ready;
  logic [3:0] fp_req0_a, fp_req0_b, fp_req1_a, fp_req1_b;
  logic [2:0] fp_req0_sel, fp_req1_sel;
  logic       fp_rsp0_valid, fp_rsp1_valid, fp_rsp_err, fp_busy;
  logic [3:0] fp_rsp_y, fp_alu_a, fp_alu_b, fp_alu_y;
  logic [2:0] fp_alu_sel;
  logic [7:0] fp_op_count;

  int n_checks = 0;
  int n_errors = 0;
  int exp_cnt  = 0;

  // External ALU model; illegal opcodes return a non-zero value so that the
  // DUT's forcing of the result to zero is observable.
  function automatic logic [3:0] alu_model(input logic [3:0] a, input logic [3:0] b,
                                           input logic [2:0] sel);
    case (sel)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      3'b100:  return a ^ b;
      default: return 4'hA;
    endcase
  endfunction

  assign rr_alu_y = alu_model(rr_alu_a, rr_alu_b, rr_alu_sel);
  assign fp_alu_y = alu_model(fp_alu_a, fp_alu_b, fp_alu_sel);

  alu_arbiter #(.RR_EN(1'b1)) u_rr (
    .clk(clk), .rst(rst),
    .req0_valid(rr_req0_valid), .req0_a(rr_req0_a), .req0_b(rr_req0_b),
    .req0_sel(rr_req0_sel), .req0_ready(rr_req0_ready),
    .req1_valid(rr_req1_valid), .req1_a(rr_req1_a), .req1_b(rr_req1_b),
    .req1_sel(rr_req1_sel), .req1_ready(rr_req1_ready),
    .rsp0_valid(rr_rsp0_valid), .rsp1_valid(rr_rsp1_valid),
    .rsp_y(rr_rsp_y), .rsp_err(rr_rsp_err),
    .alu_a(rr_alu_a), .alu_b(rr_alu_b), .alu_sel(rr_alu_sel), .alu_y(rr_alu_y),
    .busy(rr_busy), .op_count(rr_op_count)
  );

  alu_arbiter #(.RR_EN(1'b0)) u_fp (
    .clk(clk), .rst(rst),
    .req0_valid(fp_req0_valid), .req0_a(fp_req0_a), .req0_b(fp_req0_b),
    .req0_sel(fp_req0_sel), .req0_ready(fp_req0_ready),
    .req1_valid(fp_req1_valid), .req1_a(fp_req1_a), .req1_b(fp_req1_b),
    .req1_sel(fp_req1_sel), .req1_ready(fp_req1_ready),
    .rsp0_valid(fp_rsp0_valid), .rsp1_valid(fp_rsp1_valid),
    .rsp_y(fp_rsp_y), .rsp_err(fp_rsp_err),
    .alu_a(fp_alu_a), .alu_b(fp_alu_b), .alu_sel(fp_alu_sel), .alu_y(fp_alu_y),
    .busy(fp_busy), .op_count(fp_op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One requester-0 operation on the round-robin instance. Entered and left
  // one time unit after a rising edge with the DUT in IDLE.
  task automatic op0(input logic [3:0] a, input logic [3:0] b, input logic [2:0] sel,
                     input logic [3:0] ey, input logic ee);
    rr_req0_a = a; rr_req0_b = b; rr_req0_sel = sel; rr_req0_valid = 1'b1;
    #1;
    chk("op_ready0", rr_req0_ready, 32'd1);
    chk("op_ready1_low", rr_req1_ready, 32'd0);
    @(posedge clk); #1;
    rr_req0_valid = 1'b0;
    chk("op_exec_busy", rr_busy, 32'd1);
    chk("op_exec_ready0_low", rr_req0_ready, 32'd0);
    chk("op_exec_alu_a", rr_alu_a, {28'd0, a});
    chk("op_exec_rsp0_low", rr_rsp0_valid, 32'd0);
    @(posedge clk); #1;
    chk("op_rsp0", rr_rsp0_valid, 32'd1);
    chk("op_rsp1_low", rr_rsp1_valid, 32'd0);
    chk("op_rsp_y", rr_rsp_y, {28'd0, ey});
    chk("op_rsp_err", rr_rsp_err, {31'd0, ee});
    @(posedge clk); #1;
    exp_cnt++;
    chk("op_rsp0_pulse_end", rr_rsp0_valid, 32'd0);
    chk("op_count", rr_op_count, exp_cnt);
    chk("op_rsp_y_hold", rr_rsp_y, {28'd0, ey});
    chk("op_idle_busy", rr_busy, 32'd0);
    chk("op_idle_alu_sel_hold", rr_alu_sel, {29'd0, sel});
  endtask

  initial begin
    rst = 1'b1;
    rr_req0_valid = 1'b0; rr_req0_a = 4'd0; rr_req0_b = 4'd0; rr_req0_sel = 3'd0;
    rr_req1_valid = 1'b0; rr_req1_a = 4'd0; rr_req1_b = 4'd0; rr_req1_sel = 3'd0;
    fp_req0_valid = 1'b0; fp_req0_a = 4'd0; fp_req0_b = 4'd0; fp_req0_sel = 3'd0;
    fp_req1_valid = 1'b0; fp_req1_a = 4'd0; fp_req1_b = 4'd0; fp_req1_sel = 3'd0;
    #2;
    chk("rst_busy", rr_busy, 32'd0);
    chk("rst_count", rr_op_count, 32'd0);
    chk("rst_alu_sel", rr_alu_sel, 32'd0);
    chk("rst_rsp_y", rr_rsp_y, 32'd0);
    chk("rst_rsp_err", rr_rsp_err, 32'd0);
    chk("rst_rsp_valid", {rr_rsp1_valid, rr_rsp0_valid}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Basic operations, wrap-around and illegal opcode.
    op0(4'd5,  4'd3, 3'b000, 4'd8,  1'b0);
    op0(4'd5,  4'd3, 3'b001, 4'd2,  1'b0);
    op0(4'd5,  4'd3, 3'b010, 4'd1,  1'b0);
    op0(4'd5,  4'd3, 3'b011, 4'd7,  1'b0);
    op0(4'd5,  4'd3, 3'b100, 4'd6,  1'b0);
    op0(4'd15, 4'd1, 3'b000, 4'd0,  1'b0);
    op0(4'd0,  4'd1, 3'b001, 4'd15, 1'b0);
    op0(4'd9,  4'd2, 3'b110, 4'd0,  1'b1);
    op0(4'd4,  4'd4, 3'b000, 4'd8,  1'b0);

    // Round-robin contention right after reset: requester 0 first.
    rst = 1'b1; #1;
    chk("rst2_count", rr_op_count, 32'd0);
    exp_cnt = 0;
    @(posedge clk); #1 rst = 1'b0;
    rr_req0_a = 4'd5; rr_req0_b = 4'd3; rr_req0_sel = 3'b000; rr_req0_valid = 1'b1;
    rr_req1_a = 4'd5; rr_req1_b = 4'd3; rr_req1_sel = 3'b100; rr_req1_valid = 1'b1;
    #1;
    chk("rr_first_ready0", rr_req0_ready, 32'd1);
    chk("rr_first_ready1", rr_req1_ready, 32'd0);
    @(posedge clk); #1 rr_req0_valid = 1'b0;
    chk("rr_exec_ready1_low", rr_req1_ready, 32'd0);
    @(posedge clk); #1;
    chk("rr_rsp0", rr_rsp0_valid, 32'd1);
    chk("rr_rsp0_y", rr_rsp_y, 32'd8);
    @(posedge clk); #1;
    chk("rr_second_ready1", rr_req1_ready, 32'd1);
    chk("rr_second_ready0", rr_req0_ready, 32'd0);
    @(posedge clk); #1 rr_req1_valid = 1'b0;
    @(posedge clk); #1;
    chk("rr_rsp1", rr_rsp1_valid, 32'd1);
    chk("rr_rsp1_rsp0_low", rr_rsp0_valid, 32'd0);
    chk("rr_rsp1_y", rr_rsp_y, 32'd6);
    chk("rr_rsp1_err", rr_rsp_err, 32'd0);
    @(posedge clk); #1;
    chk("rr_count2", rr_op_count, 32'd2);

    // Reset during EXEC (last grant was requester 0 beforehand).
    rr_req0_a = 4'd1; rr_req0_b = 4'd1; rr_req0_sel = 3'b000; rr_req0_valid = 1'b1;
    @(posedge clk); #1;
    rr_req0_valid = 1'b0;
    chk("midrst_exec_busy", rr_busy, 32'd1);
    rst = 1'b1; #1;
    chk("midrst_busy", rr_busy, 32'd0);
    chk("midrst_count", rr_op_count, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("midrst_no_rsp", {rr_rsp1_valid, rr_rsp0_valid}, 32'd0);
      chk("midrst_count_hold", rr_op_count, 32'd0);
    end
    rr_req0_valid = 1'b1; rr_req1_valid = 1'b1;
    #1;
    chk("midrst_contention_ready0", rr_req0_ready, 32'd1);
    chk("midrst_contention_ready1", rr_req1_ready, 32'd0);
    @(posedge clk); #1 rr_req0_valid = 1'b0; rr_req1_valid = 1'b0;
    @(posedge clk); #1;
    chk("midrst_rsp0", rr_rsp0_valid, 32'd1);
    chk("midrst_rsp0_y", rr_rsp_y, 32'd2);
    @(posedge clk); #1;

    // Fixed priority: requester 1 starves while requester 0 stays valid.
    fp_req0_a = 4'd2; fp_req0_b = 4'd2; fp_req0_sel = 3'b000; fp_req0_valid = 1'b1;
    fp_req1_a = 4'd7; fp_req1_b = 4'd1; fp_req1_sel = 3'b001; fp_req1_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("fp_ready0", fp_req0_ready, 32'd1);
      chk("fp_ready1_starved", fp_req1_ready, 32'd0);
      @(posedge clk); #1;
      chk("fp_exec_no_rsp1", fp_rsp1_valid, 32'd0);
      @(posedge clk); #1;
      chk("fp_rsp0", fp_rsp0_valid, 32'd1);
      chk("fp_rsp0_y", fp_rsp_y, 32'd4);
      chk("fp_no_rsp1", fp_rsp1_valid, 32'd0);
      @(posedge clk);
    end
    #1 fp_req0_valid = 1'b0;
    #1;
    chk("fp_single_ready1", fp_req1_ready, 32'd1);
    @(posedge clk); #1 fp_req1_valid = 1'b0;
    @(posedge clk); #1;
    chk("fp_rsp1", fp_rsp1_valid, 32'd1);
    chk("fp_rsp1_y", fp_rsp_y, 32'd6);
    @(posedge clk); #1;
    chk("fp_count", fp_op_count, 32'd4);

    // Counter wrap: 256 operations from reset.
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    rr_req1_a = 4'd1; rr_req1_b = 4'd1; rr_req1_sel = 3'b000;
    for (int i = 1; i <= 256; i++) begin
      rr_req1_valid = 1'b1;
      @(posedge clk); #1 rr_req1_valid = 1'b0;
      @(posedge clk);
      @(posedge clk); #1;
      if (i == 255) chk("count_255", rr_op_count, 32'd255);
    end
    chk("count_wrap", rr_op_count, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
